dmem_responder: RTL

- Data-memory responder: the memory side of the pipeline's MEM-stage load/store interface.
- Accepts word load/store requests over a valid/ready handshake.
- Queues stores in a small in-order store buffer that drains to a single-port word array in idle cycles.
- Returns load data after a programmable latency, so the pipeline stall logic can be exercised against a non-ideal memory.

---
 rtl/dmem_responder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage load/store responder, in-order store buffer draining into a word array.
// Latency: loads respond LATENCY cycles after accept (plus drain time); misaligned or forwarded: 1 cycle.
// Backpressure: req_ready low outside IDLE, and for stores while the buffer is full. Option: DMEM_STORE_FWD_EN.
module dmem_responder #(
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = 8,
    parameter int LATENCY  = 3,
    parameter int SB_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [31:0]                 req_addr,
    input  logic [31:0]                 req_wdata,
    output logic                        rsp_valid,
    output logic [31:0]                 rsp_rdata,
    output logic                        rsp_err,
    output logic [$clog2(SB_DEPTH):0]   sb_count,
    output logic                        busy
);
    localparam int PW = $clog2(SB_DEPTH);

`ifdef DMEM_STORE_FWD_EN
    typedef enum logic [1:0] {IDLE = 2'd0, READ_WAIT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, READ_WAIT = 2'd2} state_t;
`endif

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [ADDR_W-1:0] rd_idx, rd_idx_nxt;
    logic [PW-1:0]     head, tail;

    logic [31:0]       mem     [DEPTH];
    logic [ADDR_W-1:0] sb_addr [SB_DEPTH];
    logic [31:0]       sb_data [SB_DEPTH];

    logic [ADDR_W-1:0] req_idx;
    logic              misalign, accept, sb_empty, sb_full;
    logic              push, pop, rd_fire, fwd_fire;
    logic              fwd_hit;
    logic [31:0]       fwd_data;
    logic              unused_addr_hi;

    assign req_idx        = req_addr[ADDR_W+1:2];
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
    assign misalign       = |req_addr[1:0];
    assign sb_empty       = (sb_count == '0);
    assign sb_full        = (sb_count == (PW+1)'(SB_DEPTH));
    assign req_ready      = (state == IDLE) && !(req_we && sb_full);
    assign accept         = req_valid && req_ready;
    assign busy           = (state != IDLE) || !sb_empty;

`ifdef DMEM_STORE_FWD_EN
    // Oldest-to-youngest scan so the last match (youngest store) wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (i < int'(sb_count) && sb_addr[head + PW'(i)] == req_idx) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_data[head + PW'(i)];
            end
        end
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    assign fwd_fire = accept && !misalign && !req_we && fwd_hit;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rd_idx_nxt = rd_idx;
        push       = 1'b0;
        pop        = 1'b0;
        rd_fire    = 1'b0;
        case (state)
            IDLE: begin
                // Drain only in cycles with no accepted request.
                if (accept) begin
                    if (!misalign && req_we) begin
                        push = 1'b1;
                    end else if (!misalign && !fwd_hit) begin
                        rd_idx_nxt = req_idx;
                        cnt_nxt    = 4'(LATENCY - 1);
`ifdef DMEM_STORE_FWD_EN
                        state_nxt  = READ_WAIT;
`else
                        state_nxt  = sb_empty ? READ_WAIT : DRAIN;
`endif
                    end
                end else if (!sb_empty) begin
                    pop = 1'b1;
                end
            end
`ifndef DMEM_STORE_FWD_EN
            DRAIN: begin
                pop = !sb_empty;
                if (sb_count <= (PW+1)'(1)) begin
                    state_nxt = READ_WAIT;
                    cnt_nxt   = 4'(LATENCY - 1);
                end
            end
`endif
            READ_WAIT: begin
                // The accept cycle counts as the first latency cycle, so the
                // read fires as the counter steps to zero.
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    rd_fire   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_idx    <= '0;
            head      <= '0;
            tail      <= '0;
            sb_count  <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rd_idx    <= rd_idx_nxt;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push && !pop)      sb_count <= sb_count + 1'b1;
            else if (pop && !push) sb_count <= sb_count - 1'b1;
            if (accept && misalign) begin
                rsp_err <= 1'b1;
                if (!req_we) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= '0;
                end
            end else if (fwd_fire) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= fwd_data;
            end else if (rd_fire) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= mem[rd_idx];
            end
        end
    end

    // Single array port: drain writes and READ_WAIT reads never share a cycle.
    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr[tail] <= req_idx;
            sb_data[tail] <= req_wdata;
        end
        if (pop) mem[sb_addr[head]] <= sb_data[head];
    end
endmodule
